pipelined_mc_alu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle 32-bit ALU. Performs single-cycle logic, arithmetic, shift and compare ops, plus iterative multiply, divide and remainder.
- Operand/result transfer uses a valid/ready handshake on both sides, so the block sits between the decode/issue stage and writeback.
- Result is registered, with negative, zero and overflow flags.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/pipelined_mc_alu_iter_muldiv.sv | 128 ++++++++++++
 rtl/pipelined_mc_alu.sv | 166 ++++++++++++++++
 tb/tb_pipelined_mc_alu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and op classification for pipelined_mc_alu.
// ALU_DIV_EN selects whether DIV/DIVU/REM run on the iterative divider.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOR  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLTU = 4'd11,
    OP_MUL  = 4'd12,
    OP_DIV  = 4'd13,
    OP_DIVU = 4'd14,
    OP_REM  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input alu_op_e op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM);
`else
    return (op == OP_MUL);
`endif
  endfunction

  function automatic logic is_signed_div(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/pipelined_mc_alu_iter_muldiv.sv
// Iterative shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// One bit per cycle; done pulses on the last step with res already sign-fixed.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  logic             active_q, active_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   rem_shift, trial;
  logic             q_neg;
`endif

  // MUL: acc accumulates x (shifted multiplicand) under y (shifted multiplier).
  // DIV: x holds |divisor|, y shifts the dividend out and quotient bits in.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
`ifdef ALU_DIV_EN
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    rem_shift = {rem_q, y_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, x_q};
`endif
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CNTW'(WIDTH);
      op_d     = op;
      acc_d    = '0;
      x_d      = a;
      y_d      = b;
`ifdef ALU_DIV_EN
      a_d   = a;
      b_d   = b;
      rem_d = '0;
      if (op != OP_MUL) begin
        x_d = (is_signed_div(op) && b[WIDTH-1]) ? -b : b;
        y_d = (is_signed_div(op) && a[WIDTH-1]) ? -a : a;
      end
`endif
    end else if (active_q) begin
      cnt_d = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) active_d = 1'b0;
      if (op_q == OP_MUL) begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end
`ifdef ALU_DIV_EN
      else if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        y_d   = {y_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        y_d   = {y_q[WIDTH-2:0], 1'b0};
      end
`endif
    end
  end

  assign done = active_q && (cnt_q == CNTW'(1));

  always_comb begin
`ifdef ALU_DIV_EN
    q_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    if (op_q == OP_MUL)                res = acc_d;
    else if (b_q == '0)                res = (op_q == OP_REM) ? a_q : '1;
    else if (op_q == OP_REM)           res = a_q[WIDTH-1] ? -rem_d : rem_d;
    else if ((op_q == OP_DIV) && q_neg) res = -y_d;
    else                               res = y_d;
`else
    res = (op_q == OP_MUL) ? acc_d : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
`ifdef ALU_DIV_EN
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
`endif
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
`ifdef ALU_DIV_EN
      a_q   <= a_d;
      b_q   <= b_d;
      rem_q <= rem_d;
`endif
    end
  end

endmodule

// File: rtl/pipelined_mc_alu.sv
// Multi-cycle ALU: single-cycle ops plus iterative MUL (and DIV/DIVU/REM when
// ALU_DIV_EN is defined) behind valid/ready handshakes on both sides.
module pipelined_mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: an op transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. Neither
  // side may retract valid before its transfer edge.

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             negative_q, negative_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             load;

  logic             op_known;
  alu_op_e          op_e;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_res;

  // Codes beyond the 4-bit enum only exist when OPW > 4; they produce 0.
  assign op_known = (op >> 4) == '0;
  assign op_e     = alu_op_e'(op[3:0]);
  assign sum      = a + b;
  assign diff     = a - b;
  assign shamt    = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    if (op_known) begin
      case (op_e)
        OP_ADD: begin
          alu_res = sum;
          alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          alu_res = diff;
          alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND:  alu_res = a & b;
        OP_OR:   alu_res = a | b;
        OP_XOR:  alu_res = a ^ b;
        OP_NOR:  alu_res = ~(a | b);
        OP_SLL:  alu_res = a << shamt;
        OP_SRL:  alu_res = a >> shamt;
        OP_SRA:  alu_res = $signed(a) >>> shamt;
        OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
        default: alu_res = '0;
      endcase
    end
  end

  assign md_start = (state_q == IDLE) && in_valid && op_known && is_iterative(op_e);

  iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (op_e),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (md_start) begin
            state_d = BUSY;
          end else begin
            state_d    = DONE;
            result_d   = alu_res;
            overflow_d = alu_ovf;
            load       = 1'b1;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d    = DONE;
          result_d   = md_res;
          overflow_d = 1'b0;
          load       = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      negative_d = result_d[WIDTH-1];
      zero_d     = (result_d == '0);
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipelined_mc_alu.sv
// Bench for pipelined_mc_alu: table-driven ops through a result scoreboard,
// plus hand sequences for MUL busy window, backpressure and mid-op reset.
module tb_pipelined_mc_alu;
  import alu_pkg::*;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        negative, zero, overflow, busy;
  logic [1:0]  state_dbg;

  pipelined_mc_alu #(.WIDTH(32), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [40:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  function automatic vec_t mk(input alu_op_e o_i, input logic [31:0] a_i, input logic [31:0] b_i,
                              input logic [31:0] r_i, input logic ov, input int lat);
    vec_t v;
    v.op = o_i; v.a = a_i; v.b = b_i; v.r = r_i; v.o = ov; v.lat = lat;
    return v;
  endfunction

  function automatic vec_t mk_div(input alu_op_e o_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                  input logic [31:0] r_i);
    return mk(o_i, a_i, b_i, DIV_EN ? r_i : 32'h0, 1'b0, DIV_EN ? 33 : 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic collect(input int got_lat);
    logic [40:0] e;
    logic [31:0] er;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      return;
    end
    e  = exp_q.pop_front();
    er = e[31:0];
    check("latency",  64'(got_lat), 64'(e[40:33]));
    check("result",   64'(result), 64'(er));
    check("negative", 64'(negative), 64'(er[31]));
    check("zero",     64'(zero), 64'(er == 32'h0));
    check("overflow", 64'(overflow), 64'(e[32]));
  endtask

  task automatic drive_op(input logic [3:0] o_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [31:0] r_i, input logic ov, input int lat);
    int l8;
    l8 = lat;
    exp_q.push_back({l8[7:0], ov, r_i});
    op = o_i; a = a_i; b = b_i; in_valid = 1'b1;
  endtask

  task automatic run_op(input logic [3:0] o_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] r_i, input logic ov, input int lat);
    int got;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    drive_op(o_i, a_i, b_i, r_i, ov, lat);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    got = 1;
    while (!out_valid && got < 100) begin
      @(posedge clk); #1;
      got++;
    end
    collect(got);
    @(posedge clk);
  endtask

  initial begin
    int got, bc;
    logic ir_seen;

    vecs.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1));
    vecs.push_back(mk(OP_SUB,  32'd7,        32'd7,        32'h0,        1'b0, 1));
    vecs.push_back(mk(OP_SRA,  32'hFFFFFF00, 32'd36,       32'hFFFFFFF0, 1'b0, 1));
    vecs.push_back(mk(OP_NOP,  32'h1234,     32'h5678,     32'h0,        1'b0, 1));
    vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1));
    vecs.push_back(mk(OP_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1));
    vecs.push_back(mk(OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1));
    vecs.push_back(mk(OP_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1));
    vecs.push_back(mk(OP_SLL,  32'h1,        32'd31,       32'h80000000, 1'b0, 1));
    vecs.push_back(mk(OP_SLL,  32'h3,        32'd33,       32'h6,        1'b0, 1));
    vecs.push_back(mk(OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1));
    vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1));
    vecs.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1));
    vecs.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1));
    vecs.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1));
    vecs.push_back(mk(OP_MUL,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33));
    vecs.push_back(mk(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33));
    vecs.push_back(mk(OP_MUL,  32'h10000,    32'h10000,    32'h0,        1'b0, 33));
    vecs.push_back(mk_div(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD));
    vecs.push_back(mk_div(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF));
    vecs.push_back(mk_div(OP_DIVU, 32'd32,       32'd0,        32'hFFFFFFFF));
    vecs.push_back(mk_div(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000));
    vecs.push_back(mk_div(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0));
    vecs.push_back(mk_div(OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2));
    vecs.push_back(mk_div(OP_REM,  32'd100,      32'hFFFFFFF9, 32'd2));
    vecs.push_back(mk_div(OP_DIVU, 32'hFFFFFFFF, 32'd10,       32'h19999999));
    vecs.push_back(mk_div(OP_REM,  32'd5,        32'd0,        32'd5));
    vecs.push_back(mk_div(OP_DIV,  32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF));

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_result",    64'(result), 64'd0);
    check("rst_flags",     64'({negative, zero, overflow}), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_state",     64'(state_dbg), 64'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, vecs[i].lat);

    // MUL with a competing op held on the input throughout the busy window.
    @(negedge clk);
    drive_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
    @(posedge clk); #1;
    op = OP_ADD; a = 32'd1; b = 32'd1;
    got = 1; bc = 0; ir_seen = 1'b0;
    while (!out_valid && got < 100) begin
      if (busy) bc++;
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
      got++;
    end
    in_valid = 1'b0;
    check("mul_busy_cycles", 64'(bc), 64'd32);
    check("mul_in_ready_low", 64'(ir_seen), 64'd0);
    check("mul_busy_at_done", 64'(busy), 64'd0);
    collect(got);
    @(posedge clk);

    // Backpressure on a single-cycle result.
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(out_valid ? 1 : 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result",    64'(result), 64'd1);
      check("bp_in_ready",  64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1);
    @(posedge clk); #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready",  64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(out_valid ? 1 : 0);
    @(posedge clk);

    // Reset asserted partway through a MUL.
    @(negedge clk);
    op = OP_MUL; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy",      64'(busy), 64'd0);
    check("midrst_in_ready",  64'(in_ready), 64'd1);
    check("midrst_result",    64'(result), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
